dmem_port_arbiter: RTL and testbench

// - Shares one port of the dual-port data memory (1-cycle registered read, read-first) between two requesters:
//   req0 = core load/store unit, req1 = loader/DMA engine.
// - Round-robin arbitration with bounded burst lock.
// - Returns read data to the owning requester; traps out-of-range addresses without touching RAM.

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_rr_lock_arbiter.sv | 59 +++++
 rtl/dmem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_port_arbiter_pkg : owner encoding, default depth, stats width and helper
// Rev 1.0
// ----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_0    = 2'd1,
    OWNER_1    = 2'd2
  } owner_t;

  localparam int c_DMEM_DEPTH = 140001;
  localparam int c_STAT_W     = 32;

  function automatic logic [c_STAT_W-1:0] sat_inc(input logic [c_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_rr_lock_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_port_arbiter_rr_lock_arbiter : 2-way round-robin grant with bounded lock
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_port_arbiter_rr_lock_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  localparam int                 c_CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(LOCK_MAX);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  logic               r_last;
  logic               r_lock_act;
  logic [c_CNT_W-1:0] r_lock_cnt;
  logic               w_hold;

  always_comb begin
    grant  = valid;
    w_hold = r_lock_act && valid[r_last] && (r_lock_cnt < c_LOCK_MAX);
    if (valid == 2'b11) begin
      // lock owner is always the last grantee, so "other side" is ~r_last
      grant = (w_hold ? r_last : ~r_last) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last     <= 1'b1;
      r_lock_act <= 1'b0;
      r_lock_cnt <= '0;
    end else if (grant == 2'b00) begin
      r_lock_act <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_last <= grant[1];
      if (lock[grant[1]]) begin
        r_lock_act <= 1'b1;
        if (r_lock_act && (r_last == grant[1])) begin
          r_lock_cnt <= (r_lock_cnt == c_LOCK_MAX) ? r_lock_cnt : r_lock_cnt + c_ONE;
        end else begin
          r_lock_cnt <= c_ONE;
        end
      end else begin
        r_lock_act <= 1'b0;
        r_lock_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_port_arbiter : shares one data-RAM port between LSU (req0) and DMA (req1)
// Rev 1.0 -- define DMEM_ARB_STATS_EN for grant/conflict counters
// ----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = c_DMEM_DEPTH,
  parameter int LOCK_MAX  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              err_clr,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [c_STAT_W-1:0] stat_grant0,
  output logic [c_STAT_W-1:0] stat_grant1,
  output logic [c_STAT_W-1:0] stat_conflict
`endif
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        w_valid;
  logic [1:0]        w_lock;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel;
  logic              w_we;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_din;
  owner_t            r_resp_owner;
  logic              r_resp_oor;

  assign w_valid = {req1_valid, req0_valid};
  assign w_lock  = {req1_lock, req0_lock};

  dmem_port_arbiter_rr_lock_arbiter #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .valid (w_valid),
    .lock  (w_lock),
    .grant (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_accept   = |w_grant;
  assign w_sel      = w_grant[1];
  assign w_addr     = w_sel ? req1_addr  : req0_addr;
  assign w_wdata    = w_sel ? req1_wdata : req0_wdata;
  assign w_we       = w_sel ? req1_we    : req0_we;
  assign w_oor      = w_accept && ({1'b0, w_addr} >= c_DEPTH);

  // Out-of-range commands are accepted but never reach the RAM.
  assign mem_en   = w_accept && !w_oor;
  assign mem_we   = mem_en && w_we;
  assign mem_addr = w_accept ? w_addr : r_hold_addr;
  assign mem_din  = (w_accept && w_we) ? w_wdata : r_hold_din;

  assign req0_rvalid = (r_resp_owner == OWNER_0);
  assign req1_rvalid = (r_resp_owner == OWNER_1);
  assign req0_rdata  = (req0_rvalid && !r_resp_oor) ? mem_dout : '0;
  assign req1_rdata  = (req1_rvalid && !r_resp_oor) ? mem_dout : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_addr  <= '0;
      r_hold_din   <= '0;
      r_resp_owner <= OWNER_NONE;
      r_resp_oor   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_addr <= w_addr;
      end
      if (w_accept && w_we) begin
        r_hold_din <= w_wdata;
      end
      r_resp_oor <= w_oor;
      if (w_accept && !w_we) begin
        r_resp_owner <= w_sel ? OWNER_1 : OWNER_0;
      end else begin
        r_resp_owner <= OWNER_NONE;
      end
    end
  end

  // Clear wins over a coincident error; that error is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (w_oor) begin
      err <= 1'b1;
      if (!err) begin
        err_addr <= w_addr;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else if (err_clr) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (w_grant[0]) stat_grant0 <= sat_inc(stat_grant0);
      if (w_grant[1]) stat_grant1 <= sat_inc(stat_grant1);
      if (&w_valid)   stat_conflict <= sat_inc(stat_conflict);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter : directed scenarios plus randomized run against a model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int DEPTH = 140001;
  localparam int LMAX  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid, req0_ready, req0_we, req0_lock, req0_rvalid;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock, req1_rvalid;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'h0;
  logic        err_clr, err;
  logic [31:0] err_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram     [0:255];
  logic [31:0] mdl_mem [0:255];

  always #5 clk = ~clk;

  // Read-first RAM with registered output
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr[7:0]];
      if (mem_we) ram[mem_addr[7:0]] <= mem_din;
    end
  end

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .err_clr(err_clr), .err(err), .err_addr(err_addr)
`ifdef DMEM_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 5) ? 32'hDEADBEEF : 32'hA5A50000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic lk, input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); end
    n_checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", req1_rvalid, req0_rvalid); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: en %b we %b want 0 0", mem_en, mem_we); end
    n_checks++; if (err !== 1'b0 || err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err: err %b addr %h want 0 0", err, err_addr); end
    n_checks++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", req0_rdata, req1_rdata); end
`ifdef DMEM_ARB_STATS_EN
    n_checks++; if (stat_grant0 !== 0 || stat_grant1 !== 0 || stat_conflict !== 0) begin n_fail++; $display("FAIL reset_stats: got %0d %0d %0d want 0", stat_grant0, stat_grant1, stat_conflict); end
`endif
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    drv0(1'b1, 1'b0, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready); end
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd5) begin n_fail++; $display("FAIL single_mem: en %b we %b addr %h want 1 0 5", mem_en, mem_we, mem_addr); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: rvalid %b data %h want 1 deadbeef", req0_rvalid, req0_rdata); end
    n_checks++; if (req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid1: got %b want 0", req1_rvalid); end
    tick();
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_once: got %b want 0", req0_rvalid); end
    tick();
  endtask

  task automatic test_alternate();
    apply_reset();
    drv0(1'b1, 1'b0, 1'b0, 32'd10, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'd20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (req0_ready !== 1'((k % 2) == 0) || req1_ready !== 1'((k % 2) == 1)) begin n_fail++; $display("FAIL alt_grant cyc %0d: got %b%b", k, req1_ready, req0_ready); end
      if (k > 0) begin
        if ((k % 2) == 1) begin
          n_checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== init_val(10) || req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL alt_resp0 cyc %0d: rv %b%b data %h want %h", k, req1_rvalid, req0_rvalid, req0_rdata, init_val(10)); end
        end else begin
          n_checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== init_val(20) || req0_rvalid !== 1'b0) begin n_fail++; $display("FAIL alt_resp1 cyc %0d: rv %b%b data %h want %h", k, req1_rvalid, req0_rvalid, req1_rdata, init_val(20)); end
        end
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== init_val(20)) begin n_fail++; $display("FAIL alt_last_resp: rv %b data %h want 1 %h", req1_rvalid, req1_rdata, init_val(20)); end
`ifdef DMEM_ARB_STATS_EN
    n_checks++; if (stat_conflict !== 32'd4) begin n_fail++; $display("FAIL alt_conflict: got %0d want 4", stat_conflict); end
`endif
    tick();
  endtask

  task automatic test_lock_burst();
    int exp_g [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int got;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      drv0(1'(k > 0), 1'b0, 1'b0, 32'd11, 32'h0);
      drv1(1'b1, 1'b0, 1'b1, 32'd21, 32'h0);
      @(negedge clk);
      got = req1_ready ? 1 : (req0_ready ? 0 : -1);
      n_checks++; if (got !== exp_g[k]) begin n_fail++; $display("FAIL lock_grant cyc %0d: got %0d want %0d", k, got, exp_g[k]); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_write_read();
    apply_reset();
    drv0(1'b1, 1'b1, 1'b0, 32'd7, 32'h12345678);
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd7 || mem_din !== 32'h12345678) begin n_fail++; $display("FAIL wr_mem: en %b we %b addr %h din %h", mem_en, mem_we, mem_addr, mem_din); end
    tick();
    drv0(1'b1, 1'b0, 1'b0, 32'd7, 32'h0);
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: rvalid %b we %b want 0 0", req0_rvalid, mem_we); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b1 || req0_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wr_readback: rv %b data %h want 1 12345678", req0_rvalid, req0_rdata); end
    n_checks++; if (mem_en !== 1'b0 || mem_addr !== 32'd7 || mem_din !== 32'h12345678) begin n_fail++; $display("FAIL idle_hold: en %b addr %h din %h want 0 7 12345678", mem_en, mem_addr, mem_din); end
    mdl_mem[7] = 32'h12345678;
    tick();
  endtask

  task automatic test_out_of_range();
    apply_reset();
    drv1(1'b1, 1'b0, 1'b0, 32'd140001, 32'h0);
    @(negedge clk);
    n_checks++; if (req1_ready !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_accept: ready %b en %b want 1 0", req1_ready, mem_en); end
    tick();
    drv1(1'b1, 1'b0, 1'b0, 32'd150000, 32'h0);
    @(negedge clk);
    n_checks++; if (req1_rvalid !== 1'b1 || req1_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: rv %b data %h want 1 0", req1_rvalid, req1_rdata); end
    n_checks++; if (err !== 1'b1 || err_addr !== 32'd140001) begin n_fail++; $display("FAIL oor_err: err %b addr %0d want 1 140001", err, err_addr); end
    tick();
    drv1(1'b1, 1'b0, 1'b0, 32'd140000, 32'h0);
    @(negedge clk);
    n_checks++; if (mem_en !== 1'b1 || err_addr !== 32'd140001) begin n_fail++; $display("FAIL oor_boundary: en %b addr %0d want 1 140001", mem_en, err_addr); end
    tick();
    drv1(1'b1, 1'b0, 1'b0, 32'd150002, 32'h0);
    err_clr = 1'b1;
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_clr_priority: err %b want 0", err); end
    tick();
    drv1(1'b1, 1'b0, 1'b0, 32'd150003, 32'h0);
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || err_addr !== 32'd150003) begin n_fail++; $display("FAIL oor_relatch: err %b addr %0d want 1 150003", err, err_addr); end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drv0(1'b1, 1'b0, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept: ready %b want 1", req0_ready); end
    tick();
    idle();
    rstn = 1'b0;
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: rv %b%b want 00", req1_rvalid, req0_rvalid); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset: rv %b%b want 00", req1_rvalid, req0_rvalid); end
    tick();
    drv0(1'b1, 1'b0, 1'b0, 32'd3, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_grant: got %b%b want 01", req1_ready, req0_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    int          last = 1, who = 0, streak = 0, pend = -1;
    logic [31:0] pdata = 32'h0;
    logic        m_err = 1'b0;
    logic [31:0] m_eaddr = 32'h0;
    int          g0 = 0, g1 = 0, conf = 0;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      logic        v [2];
      logic        we [2];
      logic        lk [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic        clr, en_exp, oor;
      int          g;
      for (int i = 0; i < 2; i++) begin
        v[i]  = ($urandom_range(0, 3) != 0);
        we[i] = ($urandom_range(0, 2) == 0);
        lk[i] = 1'($urandom_range(0, 1));
        a[i]  = ($urandom_range(0, 15) == 0) ? 32'(DEPTH + $urandom_range(0, 20000)) : 32'(32 + $urandom_range(0, 31));
        d[i]  = $urandom;
      end
      clr = ($urandom_range(0, 19) == 0);
      drv0(v[0], we[0], lk[0], a[0], d[0]);
      drv1(v[1], we[1], lk[1], a[1], d[1]);
      err_clr = clr;
      if (v[0] && v[1]) g = (streak > 0 && streak < LMAX) ? who : 1 - last;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
      else g = -1;
      oor    = (g >= 0) && (a[g] >= 32'(DEPTH));
      en_exp = (g >= 0) && !oor;
      @(negedge clk);
      n_checks++; if (req0_ready !== 1'(g == 0) || req1_ready !== 1'(g == 1)) begin n_fail++; $display("FAIL rnd_grant cyc %0d: got %b%b want %0d", k, req1_ready, req0_ready, g); end
      n_checks++; if (mem_en !== en_exp || mem_we !== (en_exp && we[g])) begin n_fail++; $display("FAIL rnd_mem_en cyc %0d: en %b we %b want %b", k, mem_en, mem_we, en_exp); end
      if (en_exp) begin
        n_checks++; if (mem_addr !== a[g] || (we[g] && mem_din !== d[g])) begin n_fail++; $display("FAIL rnd_mem_bus cyc %0d: addr %h din %h want %h %h", k, mem_addr, mem_din, a[g], d[g]); end
      end
      n_checks++; if (req0_rvalid !== 1'(pend == 0) || req1_rvalid !== 1'(pend == 1)) begin n_fail++; $display("FAIL rnd_rvalid cyc %0d: got %b%b want owner %0d", k, req1_rvalid, req0_rvalid, pend); end
      if (pend == 0) begin
        n_checks++; if (req0_rdata !== pdata) begin n_fail++; $display("FAIL rnd_rdata0 cyc %0d: got %h want %h", k, req0_rdata, pdata); end
      end
      if (pend == 1) begin
        n_checks++; if (req1_rdata !== pdata) begin n_fail++; $display("FAIL rnd_rdata1 cyc %0d: got %h want %h", k, req1_rdata, pdata); end
      end
      n_checks++; if (err !== m_err || (m_err && err_addr !== m_eaddr)) begin n_fail++; $display("FAIL rnd_err cyc %0d: err %b addr %h want %b %h", k, err, err_addr, m_err, m_eaddr); end
      pend = -1;
      if (g >= 0 && !we[g]) begin
        pend  = g;
        pdata = oor ? 32'h0 : mdl_mem[a[g][7:0]];
      end
      if (g >= 0 && we[g] && !oor) mdl_mem[a[g][7:0]] = d[g];
      if (clr) m_err = 1'b0;
      else if (oor) begin
        if (!m_err) m_eaddr = a[g];
        m_err = 1'b1;
      end
      if (g < 0) streak = 0;
      else begin
        if (lk[g]) streak = (streak > 0 && who == g) ? streak + 1 : 1;
        else streak = 0;
        who  = g;
        last = g;
      end
      if (clr) begin
        g0 = 0; g1 = 0; conf = 0;
      end else begin
        if (g == 0) g0++;
        if (g == 1) g1++;
        if (v[0] && v[1]) conf++;
      end
      tick();
    end
    idle();
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    n_checks++; if (stat_grant0 !== 32'(g0) || stat_grant1 !== 32'(g1) || stat_conflict !== 32'(conf)) begin n_fail++; $display("FAIL rnd_stats: got %0d %0d %0d want %0d %0d %0d", stat_grant0, stat_grant1, stat_conflict, g0, g1, conf); end
`endif
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = init_val(i);
      mdl_mem[i] = init_val(i);
    end
    idle();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_write_read();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
